sprite_render: RTL and testbench
================================

# sprite_render

Per-scanline sprite fetch and pixel output stage, directly downstream of the 16x256 sprite BRAM. It holds one 32x32, 4-bit-per-pixel sprite. On each line start it decides whether the sprite intersects the upcoming line and, if so, reads that sprite row (8 words) into a local line buffer. It then emits the sprite's 4-bit pixel index, with a transparency flag, in step with the video pixel strobe, for the compositor to overlay on playfield output.

## Interface
- AWIDTH, 8, sprite BRAM word-address width; row = addr[7:3], word-in-row = addr[2:0]
- H_WIDTH, 11, width of pixel/line counters and sprite coordinates
- clk  in  1  video clock; all logic on posedge
- reset_i  in  1  asynchronous, active-high reset
- line_start_i  in  1  one-cycle pulse at start of each line's horizontal blank
- h_count_i  in  H_WIDTH  current pixel column, valid when pixel_en_i=1
- v_count_i  in  H_WIDTH  line about to be displayed, valid at line_start_i
- pixel_en_i  in  1  one-cycle strobe per visible pixel
- sprite_en_i  in  1  sprite enable, sampled at line_start_i
- sprite_x_i  in  H_WIDTH  sprite left column, sampled at line_start_i
- sprite_y_i  in  H_WIDTH  sprite top line, sampled at line_start_i
- spr_rd_en_o  out  1  sprite BRAM read enable
- spr_rd_addr_o  out  AWIDTH  sprite BRAM read address
- spr_rd_data_i  in  16  sprite BRAM data, valid one cycle after spr_rd_en_o
- pixel_o  out  4  sprite pixel index; 0 when not valid
- pixel_valid_o  out  1  sprite pixel opaque (index != 0) at this position
- busy_o  out  1  row fetch in progress

## Operation
- State machine: IDLE, FETCH, DRAIN, READY.
- On line_start_i, latch sprite_x_i and sprite_en_i. Compute row = (v_count_i - sprite_y_i) mod 2^H_WIDTH.
- If sprite_en_i=1 and row<32, clear line_valid and go to FETCH. Otherwise clear line_valid and go to IDLE.
- FETCH: 8 cycles. On cycle k (0..7), drive spr_rd_en_o=1 and spr_rd_addr_o={row[4:0],k[2:0]}. Data arriving one cycle later is written into line buffer word k.
- After k=7, go to DRAIN for 1 cycle to capture word 7. Then go to READY and set line_valid=1.
- line_start_i in any state, including mid-FETCH, aborts the current fetch and restarts the decision above. No partial row is ever displayed.
- Pixel path: col = (h_count_i - latched_x) mod 2^H_WIDTH.
  - In range when line_valid=1 and col<32.
  - Word = col[4:2]. Nibble col[1:0]=0 selects bits [15:12] (leftmost pixel); col[1:0]=3 selects bits [3:0].
- Unsigned modulo arithmetic wraps the sprite horizontally. With H_WIDTH=11 and x=2040, h_count 0..23 displays columns 8..31. Vertical wraps the same way.
- Pixel index 0 is transparent: pixel_valid_o=0 and pixel_o=0.
- pixel_en_i during FETCH/DRAIN, or while out of range, produces pixel_o=0 and pixel_valid_o=0.

## Timing
- Reset values: state IDLE, line_valid 0, spr_rd_en_o 0, spr_rd_addr_o 0, pixel_o 0, pixel_valid_o 0, busy_o 0. Line buffer contents are don't-care while line_valid=0.
- FETCH begins the cycle after line_start_i. The first spr_rd_en_o is asserted in that cycle.
- line_valid rises 10 cycles after line_start_i (8 FETCH + 1 DRAIN + 1). The system guarantees at least 10 clocks between line_start_i and the first pixel_en_i.
- busy_o=1 exactly in FETCH and DRAIN.
- Pixel latency is 1 cycle: pixel_o/pixel_valid_o are registered from the cycle pixel_en_i=1. They hold their value when pixel_en_i=0.
- spr_rd_en_o is 0 outside FETCH. spr_rd_addr_o holds its last value.
- Asynchronous reset asserted mid-FETCH immediately forces all reset values. The first fetch after reset waits for the next line_start_i.

## Configuration
- SPRITE_HFLIP_EN defined: adds input port hflip_i (1 bit), sampled at line_start_i. When it is 1, the effective column is 31-col, applied only when in range.
- SPRITE_HFLIP_EN undefined: the port is absent and column mapping is direct.

## Test plan
- Sprite at x=100, y=50. BRAM row 0 = 1234,5678,9ABC,DEF0,... Line start with v_count=50 -> addresses 0x00..0x07 issued on consecutive cycles, busy_o high for 9 cycles. Pixel_en at h=100..103 -> pixel_o 1,2,3,4, valid=1, one cycle after each strobe.
- v_count=82 (row 32) with the same sprite -> no spr_rd_en_o pulses, all pixels valid=0. v_count=81 -> addresses 0xF8..0xFF.
- Row data with nibble 0 at column 5 -> pixel_valid_o=0 and pixel_o=0 at h=105. Neighbouring columns stay valid.
- x=2040, H_WIDTH=11 -> h=0 shows column 8. h=2047 shows column 7. h=24 shows nothing.
- line_start_i pulsed again 4 cycles into FETCH with a new v_count -> fetch restarts at word 0 of the new row. line_valid rises 10 cycles after the second pulse. Reset_i asserted mid-FETCH -> all outputs 0 immediately.
- SPRITE_HFLIP_EN with hflip_i=1 -> h=100 outputs the nibble from column 31 (bits [3:0] of word 7).

Source files
------------

// File: rtl/sprite_render_if.sv
// sprite_render_if
// Read bus between the sprite renderer and the 16-bit x 2^AWIDTH sprite BRAM.
//   spr_rd_en_o    renderer -> BRAM  read enable
//   spr_rd_addr_o  renderer -> BRAM  read address {row[4:0], word[2:0]}
//   spr_rd_data_i  BRAM -> renderer  read data, valid one cycle after spr_rd_en_o
// Modports: master (renderer side), slave (BRAM side).
interface sprite_render_if #(
    parameter int AWIDTH = 8
) ();
    logic              spr_rd_en_o;
    logic [AWIDTH-1:0] spr_rd_addr_o;
    logic [15:0]       spr_rd_data_i;

    modport master (
        output spr_rd_en_o,
        output spr_rd_addr_o,
        input  spr_rd_data_i
    );

    modport slave (
        input  spr_rd_en_o,
        input  spr_rd_addr_o,
        output spr_rd_data_i
    );
endinterface

// File: rtl/sprite_render.sv
// sprite_render
// Per-scanline sprite fetch and pixel output stage for one 32x32, 4 bpp sprite.
// At each line start it decides whether the sprite covers the upcoming line; if
// so it reads that sprite row (8 x 16-bit words) from the sprite BRAM into a
// local line buffer, then emits the sprite pixel index in step with the pixel
// strobe. Coordinates wrap modulo 2^H_WIDTH in both directions.
//
// Ports:
//   clk            video clock, all logic on posedge
//   reset_i        asynchronous active-high reset
//   line_start_i   one-cycle pulse at the start of horizontal blank
//   h_count_i      current pixel column (valid with pixel_en_i)
//   v_count_i      line about to be displayed (valid with line_start_i)
//   pixel_en_i     one-cycle strobe per visible pixel
//   sprite_en_i    sprite enable, sampled at line_start_i
//   sprite_x_i     sprite left column, sampled at line_start_i
//   sprite_y_i     sprite top line, sampled at line_start_i
//   hflip_i        horizontal flip, sampled at line_start_i (SPRITE_HFLIP_EN only)
//   spr            sprite BRAM read bus (sprite_render_if.master)
//   pixel_o        sprite pixel index, 0 when transparent / out of range
//   pixel_valid_o  pixel is opaque at this position
//   busy_o         row fetch in progress (FETCH or DRAIN)
//
// Build option: define SPRITE_HFLIP_EN to add the hflip_i port.
module sprite_render #(
    parameter int AWIDTH  = 8,
    parameter int H_WIDTH = 11
) (
    input  logic               clk,
    input  logic               reset_i,
    input  logic               line_start_i,
    input  logic [H_WIDTH-1:0] h_count_i,
    input  logic [H_WIDTH-1:0] v_count_i,
    input  logic               pixel_en_i,
    input  logic               sprite_en_i,
    input  logic [H_WIDTH-1:0] sprite_x_i,
    input  logic [H_WIDTH-1:0] sprite_y_i,
`ifdef SPRITE_HFLIP_EN
    input  logic               hflip_i,
`endif
    sprite_render_if.master    spr,
    output logic [3:0]         pixel_o,
    output logic               pixel_valid_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, READY} state_t;

    state_t             state_reg, state_next;
    logic [2:0]         k_reg, k_next;
    logic [4:0]         row_reg, row_next;
    logic [H_WIDTH-1:0] x_reg, x_next;
    logic               line_valid_reg, line_valid_next;
    logic               rd_en_reg, rd_en_next;
    logic [AWIDTH-1:0]  rd_addr_reg, rd_addr_next;
    logic               capture_reg;
    logic [2:0]         capture_idx_reg;
    logic [3:0]         pixel_reg, pixel_next;
    logic               pixel_valid_reg, pixel_valid_next;
    logic               hflip_reg, hflip_next;

    // Line buffer: one sprite row, 8 words of 4 pixels each.
    logic [15:0] line_buf [8];

    // Decision inputs for the upcoming line.
    logic [H_WIDTH-1:0] line_row;
    logic               line_hit;
    assign line_row = v_count_i - sprite_y_i;
    assign line_hit = sprite_en_i && (line_row[H_WIDTH-1:5] == '0);

`ifdef SPRITE_HFLIP_EN
    logic hflip_in;
    assign hflip_in = hflip_i;
`else
    logic hflip_in;
    assign hflip_in = 1'b0;
`endif

    // Pixel lookup: column relative to the latched sprite left edge.
    logic [H_WIDTH-1:0] col;
    logic               in_range;
    logic [4:0]         eff_col;
    logic [15:0]        sel_word;
    logic [3:0]         word_nib [4];
    logic [3:0]         sel_nib;

    assign col      = h_count_i - x_reg;
    assign in_range = line_valid_reg && (col[H_WIDTH-1:5] == '0);
    // Flipped column 31-col equals the bitwise complement of a 5-bit column.
    assign eff_col  = hflip_reg ? ~col[4:0] : col[4:0];
    assign sel_word = line_buf[eff_col[4:2]];

    // Nibble 0 is the leftmost pixel and lives in the top bits of the word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nib
            assign word_nib[gi] = sel_word[15-4*gi -: 4];
        end
    endgenerate
    assign sel_nib = word_nib[eff_col[1:0]];

    always_comb begin
        state_next       = state_reg;
        k_next           = k_reg;
        row_next         = row_reg;
        x_next           = x_reg;
        line_valid_next  = line_valid_reg;
        rd_en_next       = 1'b0;
        rd_addr_next     = rd_addr_reg;
        hflip_next       = hflip_reg;
        pixel_next       = pixel_reg;
        pixel_valid_next = pixel_valid_reg;

        if (line_start_i) begin
            // A new line always wins, even mid-fetch; the old row is dropped.
            x_next          = sprite_x_i;
            hflip_next      = hflip_in;
            row_next        = line_row[4:0];
            line_valid_next = 1'b0;
            k_next          = 3'd0;
            if (line_hit) begin
                state_next   = FETCH;
                rd_en_next   = 1'b1;
                rd_addr_next = AWIDTH'({line_row[4:0], 3'd0});
            end else begin
                state_next   = IDLE;
            end
        end else begin
            case (state_reg)
                FETCH: begin
                    if (k_reg == 3'd7) begin
                        state_next = DRAIN;
                    end else begin
                        k_next       = k_reg + 3'd1;
                        rd_en_next   = 1'b1;
                        rd_addr_next = AWIDTH'({row_reg, k_reg + 3'd1});
                    end
                end
                DRAIN: begin
                    // Word 7 is written on this same edge.
                    state_next      = READY;
                    line_valid_next = 1'b1;
                end
                default: ;
            endcase
        end

        if (pixel_en_i) begin
            pixel_next       = in_range ? sel_nib : 4'd0;
            pixel_valid_next = in_range && (sel_nib != 4'd0);
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_reg       <= IDLE;
            k_reg           <= 3'd0;
            row_reg         <= 5'd0;
            x_reg           <= '0;
            line_valid_reg  <= 1'b0;
            rd_en_reg       <= 1'b0;
            rd_addr_reg     <= '0;
            capture_reg     <= 1'b0;
            capture_idx_reg <= 3'd0;
            hflip_reg       <= 1'b0;
            pixel_reg       <= 4'd0;
            pixel_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            k_reg           <= k_next;
            row_reg         <= row_next;
            x_reg           <= x_next;
            line_valid_reg  <= line_valid_next;
            rd_en_reg       <= rd_en_next;
            rd_addr_reg     <= rd_addr_next;
            // Read data returns one cycle after the request; remember its slot.
            capture_reg     <= rd_en_reg;
            capture_idx_reg <= rd_addr_reg[2:0];
            hflip_reg       <= hflip_next;
            pixel_reg       <= pixel_next;
            pixel_valid_reg <= pixel_valid_next;
        end
    end

    // Buffer contents are meaningless until line_valid, so no reset is needed.
    // A late write from an aborted fetch is overwritten by the new fetch.
    always_ff @(posedge clk) begin
        if (capture_reg) begin
            line_buf[capture_idx_reg] <= spr.spr_rd_data_i;
        end
    end

    assign spr.spr_rd_en_o   = rd_en_reg;
    assign spr.spr_rd_addr_o = rd_addr_reg;
    assign pixel_o           = pixel_reg;
    assign pixel_valid_o     = pixel_valid_reg;
    assign busy_o            = (state_reg == FETCH) || (state_reg == DRAIN);

endmodule

// File: tb/tb_sprite_render.sv
module tb_sprite_render;
    localparam int AW = 8;
    localparam int HW = 11;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          line_start;
    logic [HW-1:0] h_count;
    logic [HW-1:0] v_count;
    logic          pixel_en;
    logic          sprite_en;
    logic [HW-1:0] sprite_x;
    logic [HW-1:0] sprite_y;
    logic          hflip;
    logic [3:0]    pixel;
    logic          pixel_valid;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural BRAM contents and line model.
    logic [15:0] mem [256];
    logic        m_hit;
    logic [HW-1:0] m_x;
    int          m_row;
    logic        m_hflip;

    always #5 clk = ~clk;

    sprite_render_if #(.AWIDTH(AW)) bus ();

    always @(posedge clk) begin
        if (bus.spr_rd_en_o) bus.spr_rd_data_i <= mem[bus.spr_rd_addr_o];
    end

    sprite_render #(.AWIDTH(AW), .H_WIDTH(HW)) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .line_start_i  (line_start),
        .h_count_i     (h_count),
        .v_count_i     (v_count),
        .pixel_en_i    (pixel_en),
        .sprite_en_i   (sprite_en),
        .sprite_x_i    (sprite_x),
        .sprite_y_i    (sprite_y),
`ifdef SPRITE_HFLIP_EN
        .hflip_i       (hflip),
`endif
        .spr           (bus.master),
        .pixel_o       (pixel),
        .pixel_valid_o (pixel_valid),
        .busy_o        (busy)
    );

    // Expected pixel index for column h from the sprite rules.
    function automatic logic [3:0] model_pix(input logic [HW-1:0] h);
        logic [HW-1:0] rel;
        int c;
        logic [15:0] w;
        rel = h - m_x;
        if (!m_hit || rel >= 11'd32) return 4'd0;
        c = int'(rel);
        if (m_hflip) c = 31 - c;
        w = mem[m_row * 8 + c / 4];
        return 4'((w >> (12 - 4 * (c % 4))) & 16'hF);
    endfunction

    task automatic start_line(input logic [HW-1:0] v, input logic [HW-1:0] y,
                              input logic [HW-1:0] x, input logic en, input logic hf);
        logic [HW-1:0] r;
        v_count = v; sprite_y = y; sprite_x = x; sprite_en = en; hflip = hf;
        line_start = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b0;
        r = v - y;
        m_hit = en && (r < 11'd32);
        m_row = int'(r[4:0]);
        m_x = x;
`ifdef SPRITE_HFLIP_EN
        m_hflip = hf;
`else
        m_hflip = 1'b0;
`endif
        $display("line v=%0d y=%0d x=%0d en=%0d hit=%0d row=%0d", v, y, x, en, m_hit, m_row);
    endtask

    // Watch 12 cycles following a line start: reads, addresses and busy.
    task automatic observe_fetch(input string name);
        logic exp_en, exp_busy;
        logic [AW-1:0] exp_addr;
        for (int c = 0; c < 12; c++) begin
            exp_en = m_hit && (c < 8);
            exp_busy = m_hit && (c < 9);
            exp_addr = AW'(m_row * 8 + c);
            n_cmp++;
            if (bus.spr_rd_en_o !== exp_en) begin
                n_err++;
                $display("FAIL %s rd_en cyc%0d got %b expected %b", name, c, bus.spr_rd_en_o, exp_en);
            end
            if (exp_en) begin
                n_cmp++;
                if (bus.spr_rd_addr_o !== exp_addr) begin
                    n_err++;
                    $display("FAIL %s rd_addr cyc%0d got %h expected %h", name, c, bus.spr_rd_addr_o, exp_addr);
                end
            end
            n_cmp++;
            if (busy !== exp_busy) begin
                n_err++;
                $display("FAIL %s busy cyc%0d got %b expected %b", name, c, busy, exp_busy);
            end
            @(posedge clk); #1;
        end
        $display("fetch %s checked hit=%0d", name, m_hit);
    endtask

    task automatic do_pixel(input string name, input logic [HW-1:0] h);
        logic [3:0] e;
        pixel_en = 1'b1; h_count = h;
        @(posedge clk); #1;
        pixel_en = 1'b0;
        e = model_pix(h);
        n_cmp++;
        if (pixel !== e || pixel_valid !== (e != 4'd0)) begin
            n_err++;
            $display("FAIL %s h=%0d got pix=%h v=%b expected pix=%h v=%b", name, h, pixel, pixel_valid, e, e != 4'd0);
        end
        $display("pixel %s h=%0d pix=%h valid=%b", name, h, pixel, pixel_valid);
    endtask

    task automatic check_idle_outputs(input string name);
        n_cmp++;
        if (bus.spr_rd_en_o !== 1'b0 || bus.spr_rd_addr_o !== 8'h00 || busy !== 1'b0 ||
            pixel !== 4'd0 || pixel_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s got en=%b addr=%h busy=%b pix=%h v=%b expected all zero", name,
                     bus.spr_rd_en_o, bus.spr_rd_addr_o, busy, pixel, pixel_valid);
        end
        $display("reset check %s", name);
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_state");
        reset_i = 1'b0;
        m_hit = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("after_release");
    endtask

    task automatic test_basic();
        mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'h9ABC; mem[3] = 16'hDEF0;
        for (int i = 4; i < 8; i++) mem[i] = 16'($urandom);
        start_line(11'd50, 11'd50, 11'd100, 1'b1, 1'b0);
        observe_fetch("basic");
        for (int h = 100; h < 104; h++) begin
            do_pixel("basic", 11'(h));
            n_cmp++;
            if (pixel !== 4'(h - 99)) begin
                n_err++;
                $display("FAIL basic_const h=%0d got %h expected %h", h, pixel, h - 99);
            end
        end
        // Output holds while the strobe is low.
        h_count = 11'd500;
        @(posedge clk); #1;
        n_cmp++;
        if (pixel !== 4'd4 || pixel_valid !== 1'b1) begin
            n_err++;
            $display("FAIL hold got pix=%h v=%b expected pix=4 v=1", pixel, pixel_valid);
        end
        do_pixel("basic_left", 11'd99);
        do_pixel("basic_right", 11'd131);
        do_pixel("basic_past", 11'd132);
    endtask

    task automatic test_miss();
        start_line(11'd82, 11'd50, 11'd100, 1'b1, 1'b0);
        observe_fetch("row32");
        do_pixel("row32", 11'd100);
        do_pixel("row32", 11'd101);
        for (int i = 248; i < 256; i++) mem[i] = 16'($urandom) | 16'h1111;
        start_line(11'd81, 11'd50, 11'd100, 1'b1, 1'b0);
        observe_fetch("row31");
        do_pixel("row31", 11'd100);
        do_pixel("row31", 11'd131);
        start_line(11'd50, 11'd50, 11'd100, 1'b0, 1'b0);
        observe_fetch("disabled");
        do_pixel("disabled", 11'd100);
    endtask

    task automatic test_transparent();
        mem[1] = 16'h5078;
        start_line(11'd50, 11'd50, 11'd100, 1'b1, 1'b0);
        observe_fetch("transp");
        for (int h = 104; h < 108; h++) do_pixel("transp", 11'(h));
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 8; i++) mem[i] = 16'($urandom) | 16'h1111;
        start_line(11'd50, 11'd50, 11'd2040, 1'b1, 1'b0);
        observe_fetch("hwrap");
        do_pixel("hwrap_h0", 11'd0);
        do_pixel("hwrap_h2047", 11'd2047);
        do_pixel("hwrap_h23", 11'd23);
        do_pixel("hwrap_h24", 11'd24);
        // Vertical wrap: top at 2040, line 5 is row 13.
        start_line(11'd5, 11'd2040, 11'd10, 1'b1, 1'b0);
        observe_fetch("vwrap");
        do_pixel("vwrap", 11'd12);
    endtask

    task automatic test_abort();
        for (int i = 80; i < 88; i++) mem[i] = 16'($urandom) | 16'h1111;
        start_line(11'd50, 11'd50, 11'd100, 1'b1, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        start_line(11'd60, 11'd50, 11'd100, 1'b1, 1'b0);
        observe_fetch("abort");
        for (int i = 0; i < 6; i++) do_pixel("abort", 11'(100 + i * 5));
    endtask

    task automatic test_valid_timing();
        mem[0] = 16'h1234;
        start_line(11'd50, 11'd50, 11'd100, 1'b1, 1'b0);
        repeat (8) begin @(posedge clk); #1; end
        // Strobe in the DRAIN cycle: line not yet valid.
        pixel_en = 1'b1; h_count = 11'd100;
        @(posedge clk); #1;
        pixel_en = 1'b0;
        n_cmp++;
        if (pixel !== 4'd0 || pixel_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain_pixel got pix=%h v=%b expected pix=0 v=0", pixel, pixel_valid);
        end
        $display("pixel drain h=100 pix=%h valid=%b", pixel, pixel_valid);
        do_pixel("first_valid", 11'd100);
    endtask

    task automatic test_reset_mid();
        start_line(11'd50, 11'd50, 11'd100, 1'b1, 1'b0);
        @(posedge clk); #2;
        reset_i = 1'b1;
        #1;
        check_idle_outputs("mid_fetch");
        @(posedge clk); #1;
        reset_i = 1'b0;
        m_hit = 1'b0;
        observe_fetch("post_reset");
        do_pixel("post_reset", 11'd100);
    endtask

    task automatic test_random();
        logic [HW-1:0] y, x, v;
        logic en;
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
            y = 11'($urandom);
            x = 11'($urandom);
            v = y + 11'($urandom_range(0, 40));
            en = ($urandom_range(0, 9) != 0);
            start_line(v, y, x, en, 1'b0);
            observe_fetch("random");
            for (int p = 0; p < 8; p++) begin
                do_pixel("random", x + 11'($urandom_range(0, 36)) - 11'd2);
            end
        end
    endtask

`ifdef SPRITE_HFLIP_EN
    task automatic test_hflip();
        mem[7] = 16'h000B;
        start_line(11'd50, 11'd50, 11'd100, 1'b1, 1'b1);
        observe_fetch("hflip");
        do_pixel("hflip_h100", 11'd100);
        n_cmp++;
        if (pixel !== 4'hB) begin
            n_err++;
            $display("FAIL hflip_const got %h expected b", pixel);
        end
        do_pixel("hflip_h131", 11'd131);
        do_pixel("hflip_h132", 11'd132);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

    initial begin
        reset_i = 1'b1; line_start = 1'b0; h_count = '0; v_count = '0;
        pixel_en = 1'b0; sprite_en = 1'b0; sprite_x = '0; sprite_y = '0; hflip = 1'b0;
        m_hit = 1'b0; m_x = '0; m_row = 0; m_hflip = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        test_reset();
        test_basic();
        test_miss();
        test_transparent();
        test_wrap();
        test_abort();
        test_valid_timing();
        test_reset_mid();
        test_random();
`ifdef SPRITE_HFLIP_EN
        test_hflip();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
